// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_ctrl_pkg
// Description : Shared encodings for the multi-cycle RV32I sequencing control:
//               opcode/funct fields, FSM states, ALU operation codes,
//               write-back and PC source selects, trap causes.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;

    // funct3 values (instr[14:12])
    localparam logic [2:0] c_f3_add_sub = 3'b000;
    localparam logic [2:0] c_f3_sll     = 3'b001;
    localparam logic [2:0] c_f3_slt     = 3'b010;
    localparam logic [2:0] c_f3_sltu    = 3'b011;
    localparam logic [2:0] c_f3_xor     = 3'b100;
    localparam logic [2:0] c_f3_srl_sra = 3'b101;
    localparam logic [2:0] c_f3_or      = 3'b110;
    localparam logic [2:0] c_f3_and     = 3'b111;
    localparam logic [2:0] c_f3_beq     = 3'b000;
    localparam logic [2:0] c_f3_bne     = 3'b001;
    localparam logic [2:0] c_f3_word    = 3'b010;
    localparam logic [2:0] c_f3_jalr    = 3'b000;

    // funct7 values (instr[31:25])
    localparam logic [6:0] c_f7_base = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_ALU    = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } trap_cause_e;

    // Operation selected by funct3 when funct7 carries no modifier
    function automatic alu_op_e f3_base_op(input logic [2:0] f3);
        case (f3)
            c_f3_add_sub: return ALU_ADD;
            c_f3_sll:     return ALU_SLL;
            c_f3_slt:     return ALU_SLT;
            c_f3_sltu:    return ALU_SLTU;
            c_f3_xor:     return ALU_XOR;
            c_f3_srl_sra: return ALU_SRL;
            c_f3_or:      return ALU_OR;
            default:      return ALU_AND;
        endcase
    endfunction

endpackage : rv_ctrl_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Combinational opcode/funct decoder. Produces the 4-bit ALU
//               operation for the EXEC step and flags illegal encodings.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import rv_ctrl_pkg::*;
#(
    parameter int SUPPORT_LUI = 1
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic       illegal
);

    alu_op_e w_op;
    logic    w_illegal;

    // Map the instruction fields to an ALU operation and a legality flag
    always_comb begin
        w_op      = ALU_ADD;
        w_illegal = 1'b0;
        case (opcode)
            c_opc_op: begin
                if (funct7 == c_f7_base) begin
                    w_op = f3_base_op(funct3);
                end else if (funct7 == c_f7_alt && funct3 == c_f3_add_sub) begin
                    w_op = ALU_SUB;
                end else if (funct7 == c_f7_alt && funct3 == c_f3_srl_sra) begin
                    w_op = ALU_SRA;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_opc_op_imm: begin
                // Upper immediate bits only act as funct7 for the shifts;
                // ADDI with bit 30 set is still an add.
                w_op = f3_base_op(funct3);
                if (funct3 == c_f3_sll && funct7 != c_f7_base) begin
                    w_illegal = 1'b1;
                end else if (funct3 == c_f3_srl_sra) begin
                    if (funct7 == c_f7_alt) begin
                        w_op = ALU_SRA;
                    end else if (funct7 != c_f7_base) begin
                        w_illegal = 1'b1;
                    end
                end
            end
            c_opc_load, c_opc_store: begin
                w_illegal = (funct3 != c_f3_word);
            end
            c_opc_branch: begin
                w_op      = ALU_SUB;
                w_illegal = (funct3 != c_f3_beq) && (funct3 != c_f3_bne);
            end
            c_opc_jal: begin
                w_op = ALU_ADD;
            end
            c_opc_jalr: begin
                w_illegal = (funct3 != c_f3_jalr);
            end
            c_opc_lui: begin
                w_illegal = (SUPPORT_LUI == 0);
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign alu_op  = w_op;
    assign illegal = w_illegal;

endmodule : alu_decoder
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Registered FETCH/DECODE/EXEC/MEM/WB sequencer for a
//               multi-cycle RV32I core with memory handshakes, a request
//               watchdog and a sticky trap state.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int SUPPORT_LUI = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        trap_clr,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [3:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic [1:0]  pc_sel,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    import rv_ctrl_pkg::*;

    state_e      state_q, state_d;
    trap_cause_e cause_q, cause_d;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [3:0] w_alu_op;
    logic       w_illegal;
    logic       w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr, w_is_lui;
    logic       w_taken;
    logic       w_req;
    logic       w_ready;
    logic       w_timeout;
    logic       w_unused_instr;

    assign w_opcode       = instr[6:0];
    assign w_funct3       = instr[14:12];
    assign w_funct7       = instr[31:25];
    assign w_unused_instr = ^{instr[24:15], instr[11:7]};

    assign w_is_load   = (w_opcode == c_opc_load);
    assign w_is_store  = (w_opcode == c_opc_store);
    assign w_is_branch = (w_opcode == c_opc_branch);
    assign w_is_jal    = (w_opcode == c_opc_jal);
    assign w_is_jalr   = (w_opcode == c_opc_jalr);
    assign w_is_lui    = (w_opcode == c_opc_lui);

    // Only BEQ/BNE reach EXEC, so funct3 picks the sense of the zero flag
    assign w_taken = (w_funct3 == c_f3_beq) ? alu_zero : ~alu_zero;

    // A memory request is outstanding in FETCH (imem) and MEM (dmem)
    assign w_req   = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign w_ready = ((state_q == ST_FETCH) && imem_ready) ||
                     ((state_q == ST_MEM)   && dmem_ready);

    alu_decoder #(
        .SUPPORT_LUI (SUPPORT_LUI)
    ) u_alu_decoder (
        .opcode  (w_opcode),
        .funct3  (w_funct3),
        .funct7  (w_funct7),
        .alu_op  (w_alu_op),
        .illegal (w_illegal)
    );

    generate
        if (MEM_TIMEOUT > 0) begin : g_watchdog
            localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

            logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

            // Restart on every state change, count each unanswered request cycle
            always_comb begin
                wd_cnt_d = wd_cnt_q;
                if (state_d != state_q) begin
                    wd_cnt_d = '0;
                end else if (w_req && !w_ready) begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
            end

            // Watchdog counter register
            always_ff @(posedge clk) begin
                if (rst) begin
                    wd_cnt_q <= '0;
                end else begin
                    wd_cnt_q <= wd_cnt_d;
                end
            end

            // The MEM_TIMEOUT-th unanswered cycle fires; a ready in it wins
            assign w_timeout = w_req && !w_ready &&
                               (wd_cnt_q == CNT_W'(MEM_TIMEOUT - 1));
        end else begin : g_no_watchdog
            assign w_timeout = 1'b0;
        end
    endgenerate

    // Next-state and trap-cause selection
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    state_d = ST_DECODE;
                end else if (w_timeout) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (w_illegal) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_is_load || w_is_store) begin
                    state_d = ST_MEM;
                end else if (w_is_branch) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_d = w_is_load ? ST_WB : ST_FETCH;
                end else if (w_timeout) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                if (trap_clr) begin
                    state_d = ST_FETCH;
                    cause_d = CAUSE_NONE;
                end
            end
            default: begin
                state_d = ST_FETCH;
                cause_d = CAUSE_NONE;
            end
        endcase
    end

    // State and trap-cause registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Datapath controls decoded from the state; all held low during reset so
    // a reset mid-instruction never retires or writes the PC
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = 4'd0;
        wb_sel     = WB_ALU;
        pc_sel     = PC_PLUS4;
        retire     = 1'b0;
        trap       = 1'b0;
        trap_cause = CAUSE_NONE;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                ST_EXEC: begin
                    alu_op = w_alu_op;
                    if (w_is_branch) begin
                        retire   = 1'b1;
                        pc_write = 1'b1;
                        pc_sel   = w_taken ? PC_BRANCH : PC_PLUS4;
                    end else if (w_is_jal) begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                    end else if (w_opcode != c_opc_op) begin
                        // I-arith, LOAD/STORE, JALR and LUI use the immediate
                        alu_src_b = 1'b1;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = w_is_store;
                    if (dmem_ready && w_is_store) begin
                        retire   = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    if (w_is_load) begin
                        wb_sel = WB_MEM;
                    end else if (w_is_jal || w_is_jalr) begin
                        wb_sel = WB_PC4;
                    end else if (w_is_lui) begin
                        wb_sel = WB_IMM;
                    end
                    if (w_is_jal) begin
                        pc_sel = PC_BRANCH;
                    end else if (w_is_jalr) begin
                        pc_sel = PC_ALU;
                    end
                end
                ST_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: begin
                    trap = 1'b0;
                end
            endcase
        end
    end

endmodule : multicycle_control_unit
`default_nettype wire

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Sequencing control for the multi-cycle RV32I core. It replaces the single-cycle combinational decoder with a registered state machine. The FSM steps each instruction through FETCH/DECODE/EXEC/MEM/WB, holds memory requests until a ready handshake, and emits a 4-bit ALU operation plus datapath strobes. It also raises a sticky trap on illegal encodings or memory timeouts.

## Interface
Parameters:
- MEM_TIMEOUT, 16: wait cycles allowed per memory request before a bus-error trap; 0 disables the watchdog.
- SUPPORT_LUI, 1: when 1, decode LUI (0110111); when 0, LUI is illegal.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- instr  in  32  instruction register contents, stable from DECODE onward
- alu_zero  in  1  ALU zero flag
- imem_ready, dmem_ready  in  1  memory handshake completions
- trap_clr  in  1  leave TRAP
- imem_req  out  1  instruction fetch request
- dmem_req, dmem_we  out  1  data request / write
- ir_write, pc_write, reg_write  out  1  datapath strobes
- alu_src_a  out  1  0=rs1, 1=PC
- alu_src_b  out  1  0=rs2, 1=immediate
- alu_op  out  4  ALU operation code
- wb_sel  out  2  0=ALU, 1=mem, 2=PC+4, 3=imm
- pc_sel  out  2  0=PC+4, 1=branch target, 2=ALU result (JALR, bit0 cleared)
- retire  out  1  one-cycle pulse per completed instruction
- trap  out  1  in TRAP state
- trap_cause  out  2  1=illegal, 2=bus timeout, 0 otherwise

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. The state is registered; all outputs decode combinationally from the state and `instr`.
- **FETCH:** `imem_req`=1.
  - On `imem_ready`: `ir_write`=1, then go to DECODE.
- **DECODE:** check legality.
  - Illegal: go to TRAP with cause 1.
  - Legal: go to EXEC.
- **EXEC** (`alu_op` from the sub-decoder):
  - R-type: src_a=0, src_b=0, then WB.
  - I-arith: src_b=1, then WB.
  - LOAD/STORE: ADD with src_b=1, then MEM.
  - BRANCH: SUB on rs1/rs2, retire. BEQ (funct3 000) is taken when `alu_zero`=1; BNE (001) is taken when `alu_zero`=0. `pc_write`=1 with pc_sel=1 if taken, else 0. Then FETCH.
  - JAL / JALR / LUI: then WB.
- **MEM:** `dmem_req`=1; `dmem_we`=1 for STORE.
  - On `dmem_ready`: LOAD goes to WB. STORE retires (`pc_write`, pc_sel=0) and goes to FETCH.
- **WB:** `reg_write`=1, `pc_write`=1, `retire`=1, then FETCH.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 3 for LUI, else 0.
  - pc_sel: 1 for JAL, 2 for JALR, else 0.
- **ALU codes:** ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9.
  - funct7=0100000 is legal only with funct3 000 (R-type only) or 101.
  - Any other non-zero funct7 is illegal.
  - I-arith never yields SUB.
- **Illegal:** unknown opcode; a branch funct3 other than 000/001; a LOAD/STORE funct3 other than 010; JALR funct3≠000.
- **TRAP:** `trap`=1; no strobes are asserted and PC is not written. It stays in TRAP until `trap_clr`=1, then goes to FETCH.

## Timing
- While `rst`=1, every output is 0. The cycle after `rst` falls, the state is FETCH and `imem_req`=1.
- Latency with ready in the first request cycle:
  - R/I/JAL/JALR/LUI: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - Branch: 3 cycles.
- Request rules:
  - A request is held until its ready is seen.
  - Ready sampled in the same cycle as the request completes it; the next state takes effect on the following edge.
  - Ready without a request is ignored.
- Watchdog:
  - The counter clears on entry to FETCH/MEM and increments each cycle the request goes unanswered.
  - When it reaches MEM_TIMEOUT with ready still low, the FSM goes to TRAP with cause 2 and drops the request.
  - Ready arriving on the timeout cycle wins.
- `rst` asserted mid-instruction aborts it: no retire and no `pc_write`.
- `trap_clr` outside TRAP is ignored.

## Structure
- Package `rv_ctrl_pkg` holds:
  - opcode, funct3 and funct7 localparams;
  - enums `state_e`, `alu_op_e`, `wb_sel_e`, `pc_sel_e`, `trap_cause_e`.
- One combinational sub-module, `alu_decoder` (opcode, funct3, funct7 → alu_op, illegal), which the verification engineer can test standalone.

## Test plan
- R-type ADD (0x002081B3) with imem_ready immediate → one ir_write pulse; alu_op=0 in EXEC; reg_write=1, wb_sel=0 and retire in cycle 4.
- LOAD LW (0x0000A103) with dmem_ready delayed 3 cycles → dmem_req high for 4 cycles with dmem_we=0; WB has wb_sel=1; retire in cycle 8.
- BNE (0x00209463), alu_zero=0 → pc_write=1 with pc_sel=1 in EXEC, retire in cycle 3; alu_zero=1 → pc_sel=0.
- Opcode 0x7F → TRAP with trap_cause=1, no reg_write or pc_write; trap_clr → FETCH the next cycle.
- MEM_TIMEOUT=4 with imem_ready never asserted → TRAP with cause 2 exactly 4 cycles after the request rises; imem_req=0 in TRAP.
- SUPPORT_LUI=0, LUI (0x123450B7) → trap_cause=1; SUPPORT_LUI=1 → wb_sel=3 and reg_write in WB.
